// File: rtl/simple_risc_pkg.sv
// Shared definitions for the SimpleRISC multi-cycle control path.
// Holds the 5-bit opcode constants (Instruction[31:27]), the sequencer
// state encodings and small opcode-classification helpers used by the
// control sequencer.
package simple_risc_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;
  localparam logic [4:0] OP_HLT  = 5'b11111;

  // Width of the shared wait counter; enough for any TIMEOUT up to 255.
  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_OF   = 3'd1,
    ST_EX   = 3'd2,
    ST_MA   = 3'd3,
    ST_RW   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  // mul/div/mod run on the iterative ALU and need a start/done handshake.
  function automatic logic is_multicycle(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Only ld and st visit the memory-access stage.
  function automatic logic is_mem(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  // ALU ops write Rd except cmp (flags only); ld writes the loaded word,
  // call writes the return address into ra.
  function automatic logic writes_rf(input logic [4:0] op);
    return ((op <= OP_ASR) && (op != OP_CMP)) || (op == OP_LD) || (op == OP_CALL);
  endfunction

  // The gap between ret and hlt is unallocated opcode space.
  function automatic logic is_illegal(input logic [4:0] op);
    return (op > OP_RET) && (op != OP_HLT);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Cycle counter shared by every handshake wait of the sequencer.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clear     - restart the count at zero (asserted on every state change)
//   enable    - count one more cycle spent waiting without ack/done
//   expired   - the wait has lasted TIMEOUT cycles including this one
module wait_timer
  import simple_risc_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMER_W-1:0] count;

  // Count held at zero across state changes so each wait starts fresh.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign expired = (count == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/risc_mc_ctrl.sv
// Multi-cycle control sequencer for the SimpleRISC datapath.
// Steps each instruction through IF -> OF -> EX -> MA -> RW, handshaking
// with instruction memory, data memory and the iterative ALU, and halts on
// hlt, on an illegal opcode or on a handshake timeout.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   opcode              - Instruction[31:27] from the instruction register
//   imem_req / imem_ack - instruction fetch handshake
//   dmem_req / dmem_we / dmem_ack - data memory handshake (we = store)
//   alu_start / alu_done - multi-cycle ALU handshake
//   ir_we, of_en, ex_en, pc_we, rf_we - datapath stage strobes
//   isRet, isSt         - operand-fetch decode hints
//   halted, err         - halt status and error cause
//   state               - current state encoding for debug
//   instr_cnt           - retired-instruction counter (wraps)
module risc_mc_ctrl
  import simple_risc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       opcode,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             alu_start,
  input  logic             alu_done,
  output logic             ir_we,
  output logic             of_en,
  output logic             isRet,
  output logic             isSt,
  output logic             ex_en,
  output logic             pc_we,
  output logic             rf_we,
  output logic             halted,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e           cur_state;
  state_e           next_state;
  logic             ex_first;
  logic             err_q;
  logic             err_set;
  logic [CNT_W-1:0] cnt_q;
  logic             timer_clear;
  logic             timer_en;
  logic             timer_expired;

  // One timer serves IF, EX and MA; a state change always restarts it.
  assign timer_clear = (next_state != cur_state);

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // State register plus the sticky error flag and the retire counter.
  // ex_first is re-armed whenever EX is left so the next multi-cycle op
  // gets exactly one start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_IF;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ex_first  <= 1'b1;
    end else begin
      cur_state <= next_state;
      if (err_set) begin
        err_q <= 1'b1;
      end
      if (cur_state == ST_RW) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      ex_first <= !((cur_state == ST_EX) && (next_state == ST_EX));
    end
  end

  // Next-state and strobe decode. Strobes depend only on the registered
  // state and the live ack/done, so acks outside their own state never
  // influence anything. Everything is forced low while rst is high so an
  // aborted instruction cannot commit in the reset cycle.
  always_comb begin
    next_state = cur_state;
    err_set    = 1'b0;
    timer_en   = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_start  = 1'b0;
    ir_we      = 1'b0;
    of_en      = 1'b0;
    isRet      = 1'b0;
    isSt       = 1'b0;
    ex_en      = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    halted     = 1'b0;

    case (cur_state)
      ST_IF: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we      = 1'b1;
          next_state = ST_OF;
        end else if (timer_expired) begin
          next_state = ST_HALT;
          err_set    = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end

      ST_OF: begin
        of_en = 1'b1;
        isRet = (opcode == OP_RET);
        isSt  = (opcode == OP_ST);
        if (is_illegal(opcode)) begin
          next_state = ST_HALT;
          err_set    = 1'b1;
        end else begin
          next_state = ST_EX;
        end
      end

      ST_EX: begin
        if (is_multicycle(opcode)) begin
          // A done left over from a previous op must not end this one,
          // so done is only honoured after the start cycle.
          alu_start = ex_first;
          if (alu_done && !ex_first) begin
            ex_en      = 1'b1;
            next_state = is_mem(opcode) ? ST_MA : ST_RW;
          end else if (timer_expired) begin
            next_state = ST_HALT;
            err_set    = 1'b1;
          end else begin
            timer_en = 1'b1;
          end
        end else if (opcode == OP_HLT) begin
          next_state = ST_HALT;
        end else begin
          ex_en      = 1'b1;
          next_state = is_mem(opcode) ? ST_MA : ST_RW;
        end
      end

      ST_MA: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_ST);
        if (dmem_ack) begin
          next_state = ST_RW;
        end else if (timer_expired) begin
          next_state = ST_HALT;
          err_set    = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end

      ST_RW: begin
        pc_we      = 1'b1;
        rf_we      = writes_rf(opcode);
        next_state = ST_IF;
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        next_state = ST_IF;
      end
    endcase

    if (rst) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      alu_start = 1'b0;
      ir_we     = 1'b0;
      of_en     = 1'b0;
      isRet     = 1'b0;
      isSt      = 1'b0;
      ex_en     = 1'b0;
      pc_we     = 1'b0;
      rf_we     = 1'b0;
      halted    = 1'b0;
    end
  end

  assign err       = err_q && !rst;
  assign state     = rst ? 3'd0 : cur_state;
  assign instr_cnt = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_risc_mc_ctrl.sv
// Self-checking bench for risc_mc_ctrl.
// A transaction-level model expands each instruction (opcode plus chosen
// handshake delays) into the exact per-cycle input/expected-output trace,
// including timeouts, halts and resets. The trace is then played into the
// DUT and every cycle is compared; a set of literal expectations on the
// directed instructions pins the model itself.
module tb_risc_mc_ctrl;

  localparam int TO = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic       rst;
    logic [4:0] opcode;
    logic       imem_ack;
    logic       dmem_ack;
    logic       alu_done;
  } stim_t;

  typedef struct packed {
    logic          imem_req;
    logic          dmem_req;
    logic          dmem_we;
    logic          alu_start;
    logic          ir_we;
    logic          of_en;
    logic          is_ret;
    logic          is_st;
    logic          ex_en;
    logic          pc_we;
    logic          rf_we;
    logic          halted;
    logic          err;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
  } outv_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    opcode = 5'd0;
  logic          imem_ack = 1'b0;
  logic          dmem_ack = 1'b0;
  logic          alu_done = 1'b0;
  logic          imem_req, dmem_req, dmem_we, alu_start, ir_we, of_en;
  logic          isRet, isSt, ex_en, pc_we, rf_we, halted, err;
  logic [2:0]    state;
  logic [CW-1:0] instr_cnt;

  stim_t stim_q[$];
  outv_t exp_q[$];
  outv_t obs_q[$];

  int  m_cnt = 0;
  bit  m_halted = 1'b0;
  bit  m_err = 1'b0;
  int  checks = 0;
  int  errors = 0;

  risc_mc_ctrl #(
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .alu_start (alu_start),
    .alu_done  (alu_done),
    .ir_we     (ir_we),
    .of_en     (of_en),
    .isRet     (isRet),
    .isSt      (isSt),
    .ex_en     (ex_en),
    .pc_we     (pc_we),
    .rf_we     (rf_we),
    .halted    (halted),
    .err       (err),
    .state     (state),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  // Inputs with every handshake line randomised; callers override the one
  // that matters in the current cycle.
  function automatic stim_t noisy_stim(input logic [4:0] op);
    stim_t s;
    s.rst      = 1'b0;
    s.opcode   = op;
    s.imem_ack = 1'($urandom_range(0, 1));
    s.dmem_ack = 1'($urandom_range(0, 1));
    s.alu_done = 1'($urandom_range(0, 1));
    return s;
  endfunction

  function automatic outv_t base_out(input logic [2:0] st);
    outv_t o;
    o       = '0;
    o.state = st;
    o.cnt   = CW'(m_cnt);
    o.err   = m_err;
    return o;
  endfunction

  function automatic void push(input stim_t s, input outv_t o);
    stim_q.push_back(s);
    exp_q.push_back(o);
  endfunction

  function automatic void enter_halt(input bit with_err);
    m_halted = 1'b1;
    if (with_err) m_err = 1'b1;
  endfunction

  function automatic void add_reset(input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s     = noisy_stim(5'($urandom_range(0, 31)));
      s.rst = 1'b1;
      push(s, outv_t'(0));
    end
    m_cnt    = 0;
    m_halted = 1'b0;
    m_err    = 1'b0;
  endfunction

  function automatic void add_halt(input int n);
    outv_t o;
    for (int i = 0; i < n; i++) begin
      o        = base_out(3'd5);
      o.halted = 1'b1;
      push(noisy_stim(5'($urandom_range(0, 31))), o);
    end
  endfunction

  // Expand one instruction. Delays give the wait index at which the
  // ack/done arrives; an index of TO or more never arrives in time.
  // rst_at >= 0 replaces that cycle of the instruction with a reset.
  function automatic void build_instr(input logic [4:0] op, input int if_d,
                                      input int ex_d, input int ma_d,
                                      input int rst_at);
    int    start;
    bit    live;
    stim_t s;
    outv_t o;
    start = stim_q.size();
    live  = 1'b1;

    for (int i = 0; i < TO; i++) begin
      s          = noisy_stim(op);
      s.imem_ack = (i == if_d);
      o          = base_out(3'd0);
      o.imem_req = 1'b1;
      o.ir_we    = s.imem_ack;
      push(s, o);
      if (s.imem_ack) break;
      if (i == TO - 1) begin
        enter_halt(1'b1);
        live = 1'b0;
      end
    end

    if (live) begin
      o        = base_out(3'd1);
      o.of_en  = 1'b1;
      o.is_ret = (op == 5'd20);
      o.is_st  = (op == 5'd15);
      push(noisy_stim(op), o);
      if (op inside {[5'd21:5'd30]}) begin
        enter_halt(1'b1);
        live = 1'b0;
      end
    end

    if (live) begin
      if (op inside {[5'd2:5'd4]}) begin
        for (int j = 0; j < TO; j++) begin
          s = noisy_stim(op);
          if (j == ex_d) s.alu_done = 1'b1;
          else if (j != 0) s.alu_done = 1'b0;
          o           = base_out(3'd2);
          o.alu_start = (j == 0);
          o.ex_en     = (j > 0) && (j == ex_d);
          push(s, o);
          if (o.ex_en) break;
          if (j == TO - 1) begin
            enter_halt(1'b1);
            live = 1'b0;
          end
        end
      end else begin
        o       = base_out(3'd2);
        o.ex_en = (op != 5'd31);
        push(noisy_stim(op), o);
        if (op == 5'd31) begin
          enter_halt(1'b0);
          live = 1'b0;
        end
      end
    end

    if (live && (op inside {5'd14, 5'd15})) begin
      for (int k = 0; k < TO; k++) begin
        s          = noisy_stim(op);
        s.dmem_ack = (k == ma_d);
        o          = base_out(3'd3);
        o.dmem_req = 1'b1;
        o.dmem_we  = (op == 5'd15);
        push(s, o);
        if (s.dmem_ack) break;
        if (k == TO - 1) begin
          enter_halt(1'b1);
          live = 1'b0;
        end
      end
    end

    if (live) begin
      o       = base_out(3'd4);
      o.pc_we = 1'b1;
      o.rf_we = op inside {[5'd0:5'd4], [5'd6:5'd12], 5'd14, 5'd19};
      push(noisy_stim(op), o);
      m_cnt = (m_cnt + 1) % (1 << CW);
    end

    if (rst_at >= 0 && start + rst_at < stim_q.size()) begin
      while (stim_q.size() > start + rst_at) begin
        void'(stim_q.pop_back());
        void'(exp_q.pop_back());
      end
      add_reset(1);
    end
  endfunction

  function automatic int rand_delay(input int lo);
    if ($urandom_range(0, 9) == 0) return TO;
    return $urandom_range(lo, TO - 1);
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    rst      = s.rst;
    opcode   = s.opcode;
    imem_ack = s.imem_ack;
    dmem_ack = s.dmem_ack;
    alu_done = s.alu_done;
  endtask

  task automatic checkOutput(input int idx);
    outv_t obs;
    #2;
    obs = '{imem_req, dmem_req, dmem_we, alu_start, ir_we, of_en, isRet, isSt,
            ex_en, pc_we, rf_we, halted, err, state, instr_cnt};
    obs_q.push_back(obs);
    checks++;
    if (obs !== exp_q[idx]) begin
      errors++;
      $display("[TB] FAIL cycle %0d outputs: got %b required %b (order imem_req,dmem_req,dmem_we,alu_start,ir_we,of_en,isRet,isSt,ex_en,pc_we,rf_we,halted,err,state,cnt)",
               idx, obs, exp_q[idx]);
    end
  endtask

  task automatic litCheck(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  initial begin
    int m_add, m_mul, m_ld, m_st, m_ret, m_ill, m_hlt, m_to, m_ok, m_nop;
    int n_start, n_exen, n_we, n_pc;
    logic [4:0] op;
    int r;

    add_reset(2);
    m_add = stim_q.size(); build_instr(5'd0,  1, 0, 0, -1);
    m_mul = stim_q.size(); build_instr(5'd2,  0, 3, 0, -1);
    m_ld  = stim_q.size(); build_instr(5'd14, 0, 0, 3, 3);
    m_st  = stim_q.size(); build_instr(5'd15, 0, 0, 2, -1);
    m_ret = stim_q.size(); build_instr(5'd20, 0, 0, 0, -1);
    m_ill = stim_q.size(); build_instr(5'd22, 0, 0, 0, -1);
    add_halt(2); add_reset(1);
    m_hlt = stim_q.size(); build_instr(5'd31, 0, 0, 0, -1);
    add_halt(2); add_reset(1);
    m_to  = stim_q.size(); build_instr(5'd0, TO, 0, 0, -1);
    add_halt(1); add_reset(1);
    m_ok  = stim_q.size(); build_instr(5'd0, TO - 1, 0, 0, -1);
    add_reset(1);
    m_nop = stim_q.size();
    repeat (5) build_instr(5'd13, 0, 0, 0, -1);

    for (int n = 0; n < 400; n++) begin
      if (m_halted) begin
        add_halt($urandom_range(1, 3));
        add_reset($urandom_range(1, 2));
      end
      r = $urandom_range(0, 19);
      if (r < 15)       op = 5'($urandom_range(0, 20));
      else if (r < 17)  op = 5'($urandom_range(21, 30));
      else if (r == 17) op = 5'd31;
      else              op = (r == 18) ? 5'd14 : 5'd15;
      build_instr(op, rand_delay(0), rand_delay(1), rand_delay(0),
                  ($urandom_range(0, 29) == 0) ? $urandom_range(0, 8) : -1);
    end
    add_reset(1);

    for (int i = 0; i < stim_q.size(); i++) begin
      applyStimulus(stim_q[i]);
      checkOutput(i);
    end

    litCheck("reset state",     int'(obs_q[0].state), 0);
    litCheck("reset imem_req",  int'(obs_q[0].imem_req), 0);
    litCheck("first IF req",    int'(obs_q[m_add].imem_req), 1);
    litCheck("add st0", int'(obs_q[m_add].state), 0);
    litCheck("add st1", int'(obs_q[m_add + 1].state), 0);
    litCheck("add st2", int'(obs_q[m_add + 2].state), 1);
    litCheck("add st3", int'(obs_q[m_add + 3].state), 2);
    litCheck("add st4", int'(obs_q[m_add + 4].state), 4);
    n_pc = 0;
    for (int k = 0; k < 4; k++) n_pc += int'(obs_q[m_add + k].pc_we) + int'(obs_q[m_add + k].rf_we);
    litCheck("add early strobes", n_pc, 0);
    litCheck("add rw pc_we", int'(obs_q[m_add + 4].pc_we), 1);
    litCheck("add rw rf_we", int'(obs_q[m_add + 4].rf_we), 1);
    litCheck("add cnt before", int'(obs_q[m_add].cnt), 0);
    litCheck("add cnt after",  int'(obs_q[m_add + 5].cnt), 1);

    n_start = 0; n_exen = 0;
    for (int k = 0; k < 7; k++) begin
      n_start += int'(obs_q[m_mul + k].alu_start);
      n_exen  += int'(obs_q[m_mul + k].ex_en);
    end
    litCheck("mul alu_start count", n_start, 1);
    litCheck("mul ex_en count", n_exen, 1);
    litCheck("mul ex_en at done", int'(obs_q[m_mul + 5].ex_en), 1);
    litCheck("mul rf_we", int'(obs_q[m_mul + 6].rf_we), 1);

    litCheck("ld cnt before", int'(obs_q[m_ld].cnt), 2);
    litCheck("ld rst rf_we", int'(obs_q[m_ld + 3].rf_we), 0);
    litCheck("ld rst pc_we", int'(obs_q[m_ld + 3].pc_we), 0);
    litCheck("ld after state", int'(obs_q[m_ld + 4].state), 0);
    litCheck("ld after cnt", int'(obs_q[m_ld + 4].cnt), 0);

    litCheck("st isSt", int'(obs_q[m_st + 1].is_st), 1);
    n_we = 0;
    for (int k = 3; k < 6; k++) n_we += int'(obs_q[m_st + k].dmem_we) + int'(obs_q[m_st + k].dmem_req);
    litCheck("st dmem req+we", n_we, 6);
    litCheck("st rw state", int'(obs_q[m_st + 6].state), 4);
    litCheck("st rf_we", int'(obs_q[m_st + 6].rf_we), 0);
    litCheck("ret isRet", int'(obs_q[m_ret + 1].is_ret), 1);

    litCheck("illegal state", int'(obs_q[m_ill + 2].state), 5);
    litCheck("illegal err", int'(obs_q[m_ill + 2].err), 1);
    litCheck("illegal halted", int'(obs_q[m_ill + 2].halted), 1);
    n_pc = 0;
    for (int k = 0; k < 5; k++) n_pc += int'(obs_q[m_ill + k].pc_we);
    litCheck("illegal pc_we", n_pc, 0);
    litCheck("hlt ex_en", int'(obs_q[m_hlt + 2].ex_en), 0);
    litCheck("hlt state", int'(obs_q[m_hlt + 3].state), 5);
    litCheck("hlt err", int'(obs_q[m_hlt + 3].err), 0);

    litCheck("timeout pre", int'(obs_q[m_to + 3].state), 0);
    litCheck("timeout state", int'(obs_q[m_to + 4].state), 5);
    litCheck("timeout err", int'(obs_q[m_to + 4].err), 1);
    litCheck("late ack state", int'(obs_q[m_ok + 4].state), 1);
    litCheck("late ack err", int'(obs_q[m_ok + 4].err), 0);

    litCheck("nop cnt 3", int'(obs_q[m_nop + 12].cnt), 3);
    litCheck("nop cnt wrap", int'(obs_q[m_nop + 16].cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/risc_mc_ctrl.md
Name: risc_mc_ctrl

Overview:
Multi-cycle control sequencer for the SimpleRISC datapath. It steps each instruction through IF -> OF -> EX -> MA -> RW and handshakes with instruction memory, data memory and the multi-cycle ALU (mul/div/mod). It generates the stage-enable strobes, and drives isRet/isSt into the operand-fetch stage. It also counts retired instructions and halts on the hlt opcode, on an illegal opcode, or on a handshake timeout.

Parameters:
TIMEOUT, 16, maximum number of cycles any wait state waits for its ack/done before an error halt (legal range 2..255)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
opcode  in  5  opcode field Instruction[31:27] from the latched instruction register
imem_req  out  1  instruction fetch request
imem_ack  in  1  instruction word valid; latched in this cycle
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write enable (store)
dmem_ack  in  1  data memory access complete
alu_start  out  1  one-cycle start pulse to the multi-cycle ALU
alu_done  in  1  multi-cycle ALU result valid
ir_we  out  1  instruction register load strobe
of_en  out  1  operand latch enable for the OF stage
isRet  out  1  ret decode to OF (selects ra as op1)
isSt  out  1  st decode to OF (rs2 = Rd field)
ex_en  out  1  EX result latch enable
pc_we  out  1  PC update strobe
rf_we  out  1  register file write enable
halted  out  1  sequencer is in HALT
err  out  1  halt caused by illegal opcode or timeout
state  out  3  current state encoding, for debug
instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- States: IF=0, OF=1, EX=2, MA=3, RW=4, HALT=5. Encodings 6 and 7 are unreachable and recover to IF on the next edge.
- Reset, synchronous: state=IF, instr_cnt=0, err=0, wait counter=0, ex_first=1.
  - During the reset cycle every output is 0.
  - Starting with the first cycle after rst deasserts, imem_req=1.
- All strobes are combinational from the registered state and the incoming ack/done. Each strobe is high for exactly one cycle per instruction unless stated otherwise.
- IF:
  - imem_req=1.
  - When imem_ack=1: ir_we=1, next state OF.
- OF, one cycle:
  - of_en=1; isRet=(opcode==10100); isSt=(opcode==01111).
  - Opcodes 10101..11110 are illegal: next state HALT, err set, of_en still 1.
  - All other opcodes: next state EX.
- EX:
  - Opcodes 00010/00011/00100 (mul/div/mod):
    - alu_start=1 only in the first EX cycle (ex_first=1).
    - alu_done is ignored in that first cycle.
    - Remain in EX until alu_done=1; ex_en=1 in that cycle.
  - All other opcodes: single cycle, ex_en=1.
  - Exit from EX: ld (01110) and st (01111) go to MA. hlt (11111) goes to HALT with err=0, and ex_en is not asserted. Everything else goes to RW.
- MA:
  - dmem_req=1 and dmem_we=(opcode==01111) for every MA cycle.
  - When dmem_ack=1: next state RW.
- RW, one cycle:
  - pc_we=1.
  - rf_we=1 for opcodes 00000..01100 except cmp (00101), and for ld (01110) and call (10011).
  - rf_we=0 for nop, st, beq, bgt, b and ret.
  - instr_cnt increments and wraps to 0 at 2^CNT_W. Next state IF.
- Timeout:
  - The wait counter clears on entry to IF, EX and MA and increments every cycle spent in that state without ack/done.
  - When it reaches TIMEOUT-1 with no ack/done, the next state is HALT and err=1.
  - An ack arriving in that same cycle wins: no error.
- HALT: absorbing. halted=1 and all strobes are 0 until rst.
- Ack/done inputs outside their own wait state are ignored.
- rst asserted mid-instruction aborts it: no pc_we/rf_we in that cycle, and the sequencer restarts at IF.

Decomposition:
- Shared package simple_risc_pkg holds:
  - the opcode localparams (OP_ADD..OP_RET, OP_HLT=11111);
  - the state encodings;
  - the helper functions is_multicycle(op), writes_rf(op) and is_mem(op).
- One sub-module, wait_timer: clear, enable, TIMEOUT parameter, expired output. It is reused for the IF, EX and MA waits.

Test Plan:
- add (00000), imem_ack on the 2nd IF cycle, single-cycle EX -> exact state sequence IF,IF,OF,EX,RW. pc_we=1 and rf_we=1 only in RW. instr_cnt goes 0->1.
- mul (00010), alu_done 3 cycles after alu_start -> alu_start high in exactly 1 cycle, ex_en coincides with alu_done, rf_we=1 in RW.
- st (01111) -> isSt=1 in OF; dmem_req=1 and dmem_we=1 through 2 wait cycles until dmem_ack; rf_we=0 in RW. ret (10100) -> isRet=1 in OF.
- Opcode 10110 -> HALT after OF, err=1, halted=1, pc_we never asserted. Opcode 11111 -> HALT with err=0.
- imem_ack held low with TIMEOUT=4 -> HALT entered 4 cycles after entering IF, err=1. Same stimulus but ack in the 4th cycle -> normal OF, no error.
- rst pulsed in the MA cycle of an ld -> no rf_we; state=IF; instr_cnt=0. Separately, CNT_W=2 with 4 retired nops -> instr_cnt wraps to 0.
